// File: rtl/hs4_tx.sv
// Clocked-to-four-phase bundled-data transmitter.
// Buffers up to two words from a valid/ready port and sends each word over a
// return-to-zero req/ack channel. The ack input is asynchronous to clk.
module hs4_tx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          req,
    input  logic          ack,
    output logic          busy,
    output logic          err,
    output logic [15:0]   tx_count
);

    localparam int CW = $clog2(SETUP_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          buf_mem [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             occ_q;
    logic                   alive_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic                   req_d, err_d;
    logic [DW-1:0]          data_d;
    logic [15:0]            cnt_d;
    logic                   push, pop;

    // in_ready comes from registered state only; alive_q keeps it low in reset
    assign in_ready = alive_q & (occ_q != 2'd2);
    assign push     = in_valid & in_ready;
    assign ack_s    = ack_sync_q[SYNC_STAGES-1];
    assign busy     = (state_q != IDLE) | (occ_q != 2'd0);

    // Buffer storage: data only, occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_q] <= in_data;
        end
    end

    // Buffer pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            alive_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Multi-flop synchroniser bringing ack into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
        end
    end

    // Handshake FSM state and registered channel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            req      <= 1'b0;
            data_out <= '0;
            tx_count <= 16'd0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            req      <= req_d;
            data_out <= data_d;
            tx_count <= cnt_d;
            err      <= err_d;
        end
    end

    // Next-state logic: load, bundling delay, req+/ack+, req-/ack-
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        req_d   = req;
        data_d  = data_out;
        cnt_d   = tx_count;
        pop     = 1'b0;
        // ack seen high before req was raised is a protocol violation
        err_d   = err | (ack_s & ((state_q == IDLE) | (state_q == SETUP)));
        case (state_q)
            IDLE: begin
                if (occ_q != 2'd0) begin
                    data_d  = buf_mem[rd_ptr_q];
                    pop     = 1'b1;
                    cyc_d   = CW'(SETUP_CYC);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cyc_q == CW'(1)) begin
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end else begin
                    cyc_d = cyc_q - CW'(1);
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    cnt_d   = tx_count + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hs4_tx.sv
// Testbench for hs4_tx: directed stimulus, scoreboard of expected words,
// and a negedge-driven four-phase responder standing in for the async side.
module tb_hs4_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        req;
    logic        ack = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] tx_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    // responder controls
    logic        resp_en = 1'b0;
    int          hi_dly = 2;
    int          lo_dly = 2;
    int          hc = 0;
    int          lc = 0;

    hs4_tx #(.DW(8), .SYNC_STAGES(2), .SETUP_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .req(req), .ack(ack),
        .busy(busy), .err(err), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Async side: raise ack hi_dly negedges after req+, drop it lo_dly after req-
    always @(negedge clk) begin
        if (!resp_en) begin
            hc = 0;
            lc = 0;
        end else if (req && !ack) begin
            hc++;
            if (hc >= hi_dly) begin ack = 1'b1; hc = 0; end
        end else if (!req && ack) begin
            lc++;
            if (lc >= lo_dly) begin ack = 1'b0; lc = 0; end
        end
    end

    // Monitor: at each req rise pop the expected word; while req is high data must hold
    logic       req_prev = 1'b0;
    logic [7:0] hold = 8'h00;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            req_prev = 1'b0;
        end else begin
            if (req && !req_prev) begin
                chk("scoreboard_has_word", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("word_order", data_out, exp_q.pop_front());
                hold = data_out;
            end else if (req) begin
                chk("data_stable", data_out, hold);
            end
            req_prev = req;
        end
    end

    // Present a word and hold it until accepted; returns 1 time unit after the push edge
    task automatic send(input logic [7:0] d);
        int i;
        in_data  = d;
        in_valid = 1'b1;
        for (i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                exp_q.push_back(d);
                break;
            end
            @(posedge clk); #1;
        end
        chk("send_accepted", i < 200, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy && !req && !ack) break;
            @(posedge clk); #1;
        end
        chk("idle_reached", i < 300, 1);
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 100; i++) begin
            if (req) break;
            @(posedge clk); #1;
        end
        chk("req_raised", i < 100, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] cnt_before;
        int          i;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_tx_count", tx_count, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready_low", in_ready, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", in_ready, 1);

        // Single word timing: push at edge 0
        send(8'hA5);
        chk("busy_after_push", busy, 1);
        @(posedge clk); #1;
        chk("t1_data_edge1", data_out, 8'hA5);
        chk("t1_req_low_edge1", req, 0);
        @(posedge clk); #1;
        chk("t1_req_high_edge2", req, 1);
        for (i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack) break;
        end
        chk("t1_ack_seen", ack, 1);
        chk("t1_req_ack_edge1", req, 1);
        @(posedge clk); #1;
        chk("t1_req_ack_edge2", req, 1);
        @(posedge clk); #1;
        chk("t1_req_ack_edge3", req, 0);
        wait_idle();
        chk("t1_tx_count", tx_count, 16'd1);
        chk("t1_busy", busy, 0);

        // Back-to-back pushes
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("b2b_in_ready_full", in_ready, 0);
        wait_idle();
        chk("b2b_tx_count", tx_count, 16'd4);
        chk("b2b_all_sent", exp_q.size(), 0);

        // Slow responder
        hi_dly = 22;
        send(8'h5A);
        wait_req();
        for (i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("slow_req_held", req, 1);
            chk("slow_data_held", data_out, 8'h5A);
        end
        chk("slow_no_err", err, 0);
        wait_idle();
        chk("slow_tx_count", tx_count, 16'd5);
        hi_dly = 2;

        // Protocol error: ack pulse while idle with empty buffer
        cnt_before = tx_count;
        resp_en = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        repeat (4) @(negedge clk);
        ack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("perr_err_set", err, 1);
        chk("perr_tx_count", tx_count, cnt_before);
        chk("perr_busy", busy, 0);
        resp_en = 1'b1;
        send(8'hC3);
        wait_idle();
        chk("perr_err_sticky", err, 1);
        chk("perr_good_count", tx_count, cnt_before + 16'd1);

        // Reset mid-handshake with one word buffered
        hi_dly = 50;
        send(8'h11);
        wait_req();
        send(8'h22);
        chk("mid_req_high", req, 1);
        chk("mid_busy", busy, 1);
        rst_n   = 1'b0;
        resp_en = 1'b0;
        ack     = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        hi_dly  = 2;
        resp_en = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rel_busy", busy, 0);
        chk("mid_rel_tx_count", tx_count, 16'h0000);
        chk("mid_rel_req", req, 0);

        // Counter wrap via preload
        force dut.tx_count = 16'hFFFE;
        @(negedge clk);
        release dut.tx_count;
        send(8'h7E);
        wait_idle();
        chk("wrap_ffff", tx_count, 16'hFFFF);
        send(8'h81);
        wait_idle();
        chk("wrap_zero", tx_count, 16'h0000);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_no_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
